// File: rtl/wb_sram_bank_ctrl_if.sv
// Wishbone classic slave-side signal bundle for the SRAM bank controller.
// The signal names keep the Caravel _i/_o suffixes as seen from the slave.
interface wb_sram_bank_ctrl_if;

   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );

endinterface

// File: rtl/wb_sram_bank_ctrl.sv
// Wishbone classic slave that maps a byte-addressed window onto a row of
// 1-cycle-latency SRAM macros through their RW port, with fully registered outputs.
module wb_sram_bank_ctrl #(
   parameter int          NUM_BANKS  = 5,
   parameter int          DATA_WIDTH = 32,
   parameter logic [31:0] ADDR_BASE  = 32'h3000_0000
) (
   input  logic                            wb_clk_i,
   input  logic                            wb_rst_ni,
   wb_sram_bank_ctrl_if.slave              wb,
   output logic [NUM_BANKS-1:0]            sram_csb0,
   output logic                            sram_web0,
   output logic [3:0]                      sram_wmask0,
   output logic [8:0]                      sram_addr0,
   output logic [DATA_WIDTH-1:0]           sram_din0,
   input  logic [NUM_BANKS*DATA_WIDTH-1:0] sram_dout0
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RDWAIT,
      ACK
   } state_t;

   state_t state_q, state_d;

   logic [2:0]            bank_q, bank_d;
   logic                  we_q, we_d;
   logic [NUM_BANKS-1:0]  csb_d;
   logic                  web_d;
   logic [3:0]            wmask_d;
   logic [8:0]            addr_d;
   logic [DATA_WIDTH-1:0] din_d;
   logic                  ack_d;
   logic [DATA_WIDTH-1:0] dat_o_d;
   logic [DATA_WIDTH-1:0] rd_word;

   logic       hit;
   logic       req;
   logic [2:0] req_bank;
   logic [8:0] req_word;
   logic       unused_adr_lsbs;

   assign hit             = (wb.wbs_adr_i[31:14] == ADDR_BASE[31:14]);
   assign req             = wb.wbs_stb_i & wb.wbs_cyc_i & hit;
   assign req_bank        = wb.wbs_adr_i[13:11];
   assign req_word        = wb.wbs_adr_i[10:2];
   assign unused_adr_lsbs = ^wb.wbs_adr_i[1:0];

   // Out-of-range banks match no entry, so their reads naturally come back as zero.
   always_comb begin
      rd_word = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (bank_q == 3'(b)) begin
            rd_word = sram_dout0[b*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Macro inputs are computed one cycle ahead so they are flops during ACCESS.
   always_comb begin
      state_d = state_q;
      bank_d  = bank_q;
      we_d    = we_q;
      csb_d   = '1;
      web_d   = sram_web0;
      wmask_d = sram_wmask0;
      addr_d  = sram_addr0;
      din_d   = sram_din0;
      dat_o_d = wb.wbs_dat_o;

      case (state_q)
         IDLE: begin
            if (req) begin
               state_d = ACCESS;
               bank_d  = req_bank;
               we_d    = wb.wbs_we_i;
               web_d   = ~wb.wbs_we_i;
               wmask_d = wb.wbs_sel_i;
               addr_d  = req_word;
               din_d   = wb.wbs_dat_i;
               for (int b = 0; b < NUM_BANKS; b++) begin
                  if (req_bank == 3'(b)) begin
                     csb_d[b] = 1'b0;
                  end
               end
            end
         end
         ACCESS: begin
            if (!wb.wbs_cyc_i) begin
               state_d = IDLE;
            end else begin
               state_d = we_q ? ACK : RDWAIT;
            end
         end
         RDWAIT: begin
            dat_o_d = rd_word;
            state_d = wb.wbs_cyc_i ? ACK : IDLE;
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      ack_d = (state_d == ACK);
   end

   // Synchronous active-low reset drops any in-flight transaction without an ack.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         state_q      <= IDLE;
         bank_q       <= '0;
         we_q         <= 1'b0;
         sram_csb0    <= '1;
         sram_web0    <= 1'b1;
         sram_wmask0  <= '0;
         sram_addr0   <= '0;
         sram_din0    <= '0;
         wb.wbs_ack_o <= 1'b0;
         wb.wbs_dat_o <= '0;
      end else begin
         state_q      <= state_d;
         bank_q       <= bank_d;
         we_q         <= we_d;
         sram_csb0    <= csb_d;
         sram_web0    <= web_d;
         sram_wmask0  <= wmask_d;
         sram_addr0   <= addr_d;
         sram_din0    <= din_d;
         wb.wbs_ack_o <= ack_d;
         wb.wbs_dat_o <= dat_o_d;
      end
   end

endmodule
